train_seq_ctrl: RTL and testbench

- Epoch sequencer for the output neuron.
- Clears the neuron's final/loss registers, then enables it for exactly the cycles needed to produce final and loss.
- Judges convergence from the registered loss, then hands off to the backprop block through a req/ack handshake.
- Repeats until the neuron converges, MAX_EPOCHS is exhausted, backprop times out, or software aborts.

---
 rtl/train_seq_if.sv | 23 ++
 rtl/train_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_train_seq_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/train_seq_if.sv
// Neuron control and backprop handshake bundle between the epoch sequencer and its neighbours.
interface train_seq_if #(
    parameter int unsigned LOSS_W = 46
) ();
    logic [3:0]        target_i;
    logic [LOSS_W-1:0] loss_i;
    logic              zero_end_check_i;
    logic              bp_ack_i;
    logic              neuron_en_o;
    logic              zero_final_o;
    logic              zero_loss_o;
    logic              bp_req_o;

    modport master (
        input  target_i, loss_i, zero_end_check_i, bp_ack_i,
        output neuron_en_o, zero_final_o, zero_loss_o, bp_req_o
    );

    modport slave (
        output target_i, loss_i, zero_end_check_i, bp_ack_i,
        input  neuron_en_o, zero_final_o, zero_loss_o, bp_req_o
    );
endinterface

// File: rtl/train_seq_ctrl.sv
// Epoch sequencer for the output neuron: clear, two forward cycles, convergence check,
// then a backprop req/ack handshake, repeated until converged, exhausted, timed out or aborted.
module train_seq_ctrl #(
    parameter int unsigned MAX_EPOCHS  = 16,
    parameter int unsigned LOSS_W      = 46,
    parameter int unsigned LOSS_THRESH = 0,
    parameter int unsigned BP_TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    train_seq_if.master nif,
    output logic        busy_o,
    output logic        done_o,
    output logic        converged_o,
    output logic        timeout_o,
    output logic [7:0]  epoch_o
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FWD1, S_FWD2, S_CHECK, S_BP, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   epoch_q, epoch_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               conv_q, conv_d;
    logic               tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               en_q, en_d;
    logic               zclr_q, zclr_d;
    logic               req_q, req_d;
    logic               loss_ok;

    // A zero target never updates loss, so it cannot converge through the loss path.
    assign loss_ok = (nif.target_i != 4'd0) && (nif.loss_i <= LOSS_W'(LOSS_THRESH));

    always_comb begin
        state_d = state_q;
        epoch_d = epoch_q;
        wait_d  = wait_q;
        conv_d  = conv_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    epoch_d = '0;
                    conv_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            S_CLEAR: state_d = S_FWD1;
            S_FWD1:  state_d = S_FWD2;
            S_FWD2:  state_d = S_CHECK;
            S_CHECK: begin
                if (nif.zero_end_check_i || loss_ok) begin
                    state_d = S_DONE;
                    conv_d  = 1'b1;
                end else if (epoch_q == CNT_W'(MAX_EPOCHS - 1)) begin
                    state_d = S_DONE;
                    conv_d  = 1'b0;
                end else begin
                    state_d = S_BP;
                    wait_d  = '0;
                end
            end
            S_BP: begin
                if (nif.bp_ack_i) begin
                    state_d = S_CLEAR;
                    epoch_d = epoch_q + CNT_W'(1);
                end else if (wait_q == CNT_W'(BP_TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d  = wait_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every decision above while a run is in progress.
        if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_IDLE;
            epoch_d = epoch_q;
            conv_d  = 1'b0;
            tmo_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        en_d   = (state_d == S_FWD1) || (state_d == S_FWD2);
        zclr_d = (state_d == S_CLEAR);
        req_d  = (state_d == S_BP);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            epoch_q <= '0;
            wait_q  <= '0;
            conv_q  <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            zclr_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            epoch_q <= epoch_d;
            wait_q  <= wait_d;
            conv_q  <= conv_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            zclr_q  <= zclr_d;
            req_q   <= req_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign converged_o      = conv_q;
    assign timeout_o        = tmo_q;
    assign epoch_o          = epoch_q;
    assign nif.neuron_en_o  = en_q;
    assign nif.zero_final_o = zclr_q;
    assign nif.zero_loss_o  = zclr_q;
    assign nif.bp_req_o     = req_q;
endmodule

// File: tb/tb_train_seq_ctrl.sv
// Directed bench for train_seq_ctrl built with MAX_EPOCHS=4 and BP_TIMEOUT=8.
module tb_train_seq_ctrl;
    localparam int unsigned LOSS_W = 46;

    // Output vector bit order: busy done conv tmo en zf zl req
    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_CLEAR = 8'b1000_0110;
    localparam logic [7:0] V_FWD   = 8'b1000_1000;
    localparam logic [7:0] V_CHECK = 8'b1000_0000;
    localparam logic [7:0] V_BP    = 8'b1000_0001;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic       busy_o, done_o, converged_o, timeout_o;
    logic [7:0] epoch_o;
    int         n_vec = 0;
    int         n_err = 0;

    train_seq_if #(.LOSS_W(LOSS_W)) nif ();

    train_seq_ctrl #(
        .MAX_EPOCHS (4),
        .LOSS_W     (LOSS_W),
        .LOSS_THRESH(0),
        .BP_TIMEOUT (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .nif        (nif),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .converged_o(converged_o),
        .timeout_o  (timeout_o),
        .epoch_o    (epoch_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] exp_v, input logic [7:0] exp_ep);
        chk({tag, "_outs"}, {56'd0, busy_o, done_o, converged_o, timeout_o,
                             nif.neuron_en_o, nif.zero_final_o, nif.zero_loss_o, nif.bp_req_o},
            {56'd0, exp_v});
        chk({tag, "_epoch"}, {56'd0, epoch_o}, {56'd0, exp_ep});
    endtask

    task automatic do_start;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
    endtask

    // Checks CLEAR, FWD1, FWD2 and CHECK, starting in CLEAR and ending in CHECK.
    task automatic pass(input string tag, input logic [7:0] ep);
        chk_st({tag, "_clr"}, V_CLEAR, ep); tick;
        chk_st({tag, "_fwd1"}, V_FWD, ep);  tick;
        chk_st({tag, "_fwd2"}, V_FWD, ep);  tick;
        chk_st({tag, "_chk"}, V_CHECK, ep);
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        nif.target_i = 4'd0; nif.loss_i = '0; nif.zero_end_check_i = 1'b0; nif.bp_ack_i = 1'b0;
        tick; tick;
        chk_st("reset", V_IDLE, 8'd0);
        rst_i = 1'b1;
        tick;

        // 1: immediate converge through the zero-end flag
        nif.zero_end_check_i = 1'b1;
        do_start;
        pass("t1", 8'd0);
        tick;
        chk_st("t1_done", 8'b1110_0000, 8'd0);
        tick;
        chk_st("t1_idle", 8'b0010_0000, 8'd0);

        // 2: two handshakes with 3-cycle ack latency, then converge on loss
        nif.zero_end_check_i = 1'b0; nif.target_i = 4'd5; nif.loss_i = LOSS_W'(9);
        do_start;
        for (int e = 0; e < 2; e++) begin
            pass("t2", 8'(e));
            tick;
            chk_st("t2_bp1", V_BP, 8'(e)); tick;
            chk_st("t2_bp2", V_BP, 8'(e)); tick;
            chk_st("t2_bp3", V_BP, 8'(e));
            nif.bp_ack_i = 1'b1;
            tick;
            nif.bp_ack_i = 1'b0;
        end
        nif.loss_i = '0;
        pass("t2_last", 8'd2);
        tick;
        chk_st("t2_done", 8'b1110_0000, 8'd2);
        tick;

        // 3: epoch exhaustion, loss never low enough
        nif.loss_i = LOSS_W'(100);
        do_start;
        for (int e = 0; e < 3; e++) begin
            pass("t3", 8'(e));
            tick;
            chk_st("t3_bp", V_BP, 8'(e));
            nif.bp_ack_i = 1'b1;
            tick;
            nif.bp_ack_i = 1'b0;
        end
        pass("t3_last", 8'd3);
        tick;
        chk_st("t3_done", 8'b1100_0000, 8'd3);
        tick;

        // 4a: backprop timeout, req held exactly 8 cycles
        nif.target_i = 4'd3; nif.loss_i = LOSS_W'(4);
        do_start;
        pass("t4a", 8'd0);
        tick;
        for (int i = 0; i < 8; i++) begin
            chk_st("t4a_req", V_BP, 8'd0);
            tick;
        end
        chk_st("t4a_done", 8'b1101_0000, 8'd0);
        tick;
        chk_st("t4a_idle", 8'b0001_0000, 8'd0);

        // 4b: ack on the eighth request cycle beats the timeout
        do_start;
        pass("t4b", 8'd0);
        tick;
        for (int i = 0; i < 7; i++) tick;
        chk_st("t4b_req8", V_BP, 8'd0);
        nif.bp_ack_i = 1'b1;
        tick;
        nif.bp_ack_i = 1'b0;
        chk_st("t4b_clear", V_CLEAR, 8'd1);

        // 6b: synchronous reset during FWD
        tick;
        chk_st("t6b_fwd", V_FWD, 8'd1);
        rst_i = 1'b0;
        tick;
        chk_st("t6b_rst", V_IDLE, 8'd0);
        rst_i = 1'b1;
        tick;

        // 5: zero target with zero loss must not converge; start while busy ignored
        nif.target_i = 4'd0; nif.loss_i = '0;
        do_start;
        pass("t5", 8'd0);
        tick;
        chk_st("t5_bp", V_BP, 8'd0);
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk_st("t5_busy_start", V_BP, 8'd0);
        abort_i = 1'b1;
        tick;
        abort_i = 1'b0;
        chk_st("t5_abort", V_IDLE, 8'd0);

        // 6a: start beats abort in IDLE; abort beats ack in BP and holds epoch
        nif.target_i = 4'd3; nif.loss_i = LOSS_W'(4);
        start_i = 1'b1; abort_i = 1'b1;
        tick;
        start_i = 1'b0; abort_i = 1'b0;
        pass("t6a", 8'd0);
        tick;
        nif.bp_ack_i = 1'b1;
        tick;
        nif.bp_ack_i = 1'b0;
        pass("t6a_2", 8'd1);
        tick;
        chk_st("t6a_bp", V_BP, 8'd1);
        abort_i = 1'b1; nif.bp_ack_i = 1'b1;
        tick;
        abort_i = 1'b0; nif.bp_ack_i = 1'b0;
        chk_st("t6a_abort", V_IDLE, 8'd1);
        tick;
        chk_st("t6a_nodone", V_IDLE, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
